// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pipe_stage_reg_pkg
//  Purpose : Shared constants and types for the MiniMIPS32 inter-stage
//            pipeline registers: stall bus width, STOP/NOSTOP encodings,
//            PC reset/zero words, stage indices and the per-edge action code.
//  Rev     : 1.0  initial release
// ============================================================================
package pipe_stage_reg_pkg;

    localparam int          STALL_BUS = 6;
    localparam int          ADDR_BUS  = 32;

    localparam logic        STOP      = 1'b1;
    localparam logic        NOSTOP    = 1'b0;

    localparam logic [31:0] PC_INIT   = 32'h0000_0000;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam int          STG_IF    = 0;
    localparam int          STG_ID    = 1;
    localparam int          STG_EXE   = 2;
    localparam int          STG_MEM   = 3;
    localparam int          STG_WB    = 4;

    // What the stage register does on the next rising edge (reset excluded,
    // it is handled directly in the register process).
    typedef enum logic [2:0] {
        ACT_HOLD    = 3'd0,
        ACT_FLUSH   = 3'd1,
        ACT_BUBBLE  = 3'd2,
        ACT_DISCARD = 3'd3,
        ACT_LOAD    = 3'd4
    } stage_act_e;

endpackage : pipe_stage_reg_pkg
`default_nettype wire

// File: rtl/pipe_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module  : pipe_sat_counter
//  Purpose : Saturating up-counter used for pipeline performance statistics.
//  Ports   : clk   - clock
//            clr   - synchronous clear (highest priority)
//            inc   - count enable; count sticks at all-ones
//            count - current value
//  Rev     : 1.0  initial release
// ============================================================================
module pipe_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : pipe_sat_counter
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module  : pipe_stage_reg
//  Purpose : Generic inter-stage pipeline register (IF/ID, ID/EXE, EXE/MEM,
//            MEM/WB) with bubble insertion, flush and an optional sticky
//            flush that drops the stale upstream instruction released after
//            a stall.
//  Ports   : cpu_clk_50M, cpu_rst      - clock, synchronous active-high reset
//            in_pc/in_data/in_valid    - upstream stage
//            stall                     - stall vector (1 = STOP)
//            flush                     - exception/redirect flush
//            out_pc/out_data/out_valid - registered downstream stage
//            flush_pend                - sticky flush pending
//            perf_stall_cnt/perf_bubble_cnt - only with PIPE_STAGE_PERF_EN
//  Config  : `define PIPE_STAGE_PERF_EN adds saturating hold/bubble counters.
//  Rev     : 1.0  initial release
// ============================================================================
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                 ADDR_W       = ADDR_BUS,
    parameter int                 DATA_W       = 32,
    parameter int                 STALL_W      = STALL_BUS,
    parameter int                 STAGE_IDX    = STG_ID,
    parameter logic [ADDR_W-1:0]  RESET_PC     = ADDR_W'(PC_INIT),
    parameter logic [ADDR_W-1:0]  BUBBLE_PC    = ADDR_W'(ZERO_WORD),
    parameter int                 FLUSH_STICKY = 1
) (
    input  logic                cpu_clk_50M,
    input  logic                cpu_rst,
    input  logic [ADDR_W-1:0]   in_pc,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    output logic [ADDR_W-1:0]   out_pc,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    output logic                flush_pend
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0]         perf_stall_cnt,
    output logic [15:0]         perf_bubble_cnt
`endif
);

    localparam logic c_sticky_en = (FLUSH_STICKY != 0);

    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_flush_pend;

    logic              w_up;
    logic              w_dn;
    stage_act_e        w_act;
    logic              w_stall_unused;

    assign w_up           = (stall[STAGE_IDX]   == STOP);
    assign w_dn           = (stall[STAGE_IDX+1] == STOP);
    // Only two bits of the stall bus belong to this boundary.
    assign w_stall_unused = ^stall;

    always_comb begin
        w_act = ACT_HOLD;
        if (flush) begin
            w_act = ACT_FLUSH;
        end else if (w_up && !w_dn) begin
            w_act = ACT_BUBBLE;
        end else if (!w_up && r_flush_pend) begin
            // Upstream was stalled when the flush hit, so what it releases
            // now is the pre-flush instruction: drop it.
            w_act = ACT_DISCARD;
        end else if (!w_up) begin
            // up=0/dn=1 is a controller error and is deliberately a load.
            w_act = ACT_LOAD;
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_pc         <= RESET_PC;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            case (w_act)
                ACT_FLUSH: begin
                    r_pc         <= RESET_PC;
                    r_data       <= '0;
                    r_valid      <= 1'b0;
                    r_flush_pend <= c_sticky_en & w_up;
                end
                ACT_BUBBLE: begin
                    r_pc    <= BUBBLE_PC;
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end
                ACT_DISCARD: begin
                    r_pc         <= BUBBLE_PC;
                    r_data       <= '0;
                    r_valid      <= 1'b0;
                    r_flush_pend <= 1'b0;
                end
                ACT_LOAD: begin
                    r_pc    <= in_pc;
                    r_data  <= in_data;
                    r_valid <= in_valid;
                end
                default: begin
                    // hold everything
                end
            endcase
        end
    end

    assign out_pc     = r_pc;
    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign flush_pend = r_flush_pend;

`ifdef PIPE_STAGE_PERF_EN
    logic w_inc_stall;
    logic w_inc_bubble;

    assign w_inc_stall  = !cpu_rst && (w_act == ACT_HOLD);
    assign w_inc_bubble = !cpu_rst && ((w_act == ACT_BUBBLE) || (w_act == ACT_DISCARD));

    pipe_sat_counter #(.WIDTH(16)) u_stall_cnt (
        .clk   (cpu_clk_50M),
        .clr   (cpu_rst),
        .inc   (w_inc_stall),
        .count (perf_stall_cnt)
    );

    pipe_sat_counter #(.WIDTH(16)) u_bubble_cnt (
        .clk   (cpu_clk_50M),
        .clr   (cpu_rst),
        .inc   (w_inc_bubble),
        .count (perf_bubble_cnt)
    );
`endif

`ifndef SYNTHESIS
    generate
        if (STAGE_IDX + 1 >= STALL_W) begin : g_idx_check
            $error("pipe_stage_reg: STAGE_IDX+1 must be below STALL_W");
        end
    endgenerate

    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst) begin
            assert (!(!w_up && w_dn))
                else $warning("pipe_stage_reg: non-monotonic stall (up=0, dn=1)");
        end
    end
`endif

endmodule : pipe_stage_reg
`default_nettype wire
